// File: rtl/regfile_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_pkg
//
// Purpose: shared constants, types and helpers for the register-file write
// arbiter and its optional load scoreboard.
//
// Contents:
//   WORD_LEN     data width of every write path
//   NUM_REGS     writable registers in the register file (0..14)
//   REG_ADDR_W   register address width
//   PC_ADDR      address 15, the non-writable program-counter slot
//   req_e        requester identity (writeback stage / memory return)
//   wr_req_t     one write request {addr, data}
//   is_writable  true when an address names a real register-file entry
// ---------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

  localparam int WORD_LEN   = 32;
  localparam int NUM_REGS   = 15;
  localparam int REG_ADDR_W = 4;

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = 4'd15;

  // Identity of the two requesters sharing the write port.
  typedef enum logic {
    REQ_WB  = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  // One write request as seen by the arbiter.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WORD_LEN-1:0]   data;
  } wr_req_t;

  // Address 15 is the PC slot: requests to it are accepted but never written.
  function automatic logic is_writable(input logic [REG_ADDR_W-1:0] addr);
    return addr != PC_ADDR;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_scoreboard.sv
// ---------------------------------------------------------------------------
// regwr_scoreboard
//
// Purpose: tracks which registers have a load in flight. A reservation
// handshake marks a register busy; the memory-return write to that register
// clears it. The hazard unit reads busy_o.
//
// Ports:
//   clk_i        system clock, state updates on posedge
//   rst_ni       asynchronous active-low reset
//   rsv_valid_i  reservation request
//   rsv_addr_i   register to reserve
//   rsv_ready_o  reservation accepted this cycle
//   clr_valid_i  a memory-return write transfers this cycle
//   clr_addr_i   destination of that memory-return write
//   busy_o       one bit per register 0..14, set = load outstanding
// ---------------------------------------------------------------------------
module regwr_scoreboard
  import regfile_write_arbiter_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rsv_valid_i,
  input  logic [REG_ADDR_W-1:0] rsv_addr_i,
  output logic                  rsv_ready_o,
  input  logic                  clr_valid_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  output logic [NUM_REGS-1:0]   busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] rsvSel;
  logic [NUM_REGS-1:0] setMask;
  logic [NUM_REGS-1:0] clrMask;
  logic                rsvTargetBusy;
  logic                rsvFire;

  // Decode both addresses into one-hot masks. Address 15 decodes to no
  // bit at all, so PC-slot traffic can never touch the vector.
  always_comb begin
    rsvSel  = '0;
    clrMask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rsvSel[i]  = (rsv_addr_i == REG_ADDR_W'(i));
      clrMask[i] = clr_valid_i && (clr_addr_i == REG_ADDR_W'(i));
    end
  end

  // Ready looks at the registered (pre-clear) vector, so a reservation of a
  // register whose load returns this same cycle waits one cycle and retries.
  assign rsvTargetBusy = |(busy_q & rsvSel);
  assign rsv_ready_o   = rst_ni && is_writable(rsv_addr_i) && !rsvTargetBusy;
  assign rsvFire       = rsv_valid_i && rsv_ready_o;
  assign setMask       = rsvFire ? rsvSel : '0;

  // Clear is applied after set so a returning load always wins.
  assign busy_d = (busy_q | setMask) & ~clrMask;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose: shares the register file's single write port between the
// pipeline writeback stage (WB) and the multi-cycle memory-return path
// (MEM). Round-robin arbitration with valid/ready handshakes; the winning
// write is registered for one cycle and the register file commits it on the
// following negative clock edge. The register file is never back-pressured.
//
// Optional feature: define REGWR_SCOREBOARD_EN to build in the load
// scoreboard (regwr_scoreboard). Without it busy is 0, rsv_ready follows
// reset only, and rsv_valid/rsv_addr are ignored.
//
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   wb_valid/wb_ready/addr/data     writeback request channel
//   mem_valid/mem_ready/addr/data   memory-return request channel
//   rsv_valid/rsv_ready/rsv_addr    load reservation channel
//   rf_we/rf_waddr/rf_wdata         registered register-file write port
//   busy                            outstanding-load flags, registers 0..14
// ---------------------------------------------------------------------------
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int WordLen = WORD_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [WordLen-1:0]    wb_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [WordLen-1:0]    mem_data,
  input  logic                  rsv_valid,
  output logic                  rsv_ready,
  input  logic [REG_ADDR_W-1:0] rsv_addr,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [WordLen-1:0]    rf_wdata,
  output logic [NUM_REGS-1:0]   busy
);

  req_e                  lastGrant_q;
  req_e                  lastGrant_d;
  logic                  grantWb;
  logic                  grantMem;
  logic                  transfer;
  wr_req_t               wbReq;
  wr_req_t               memReq;
  wr_req_t               winReq;
  logic                  rfWe_q;
  logic                  rfWe_d;
  logic [REG_ADDR_W-1:0] rfWaddr_q;
  logic [REG_ADDR_W-1:0] rfWaddr_d;
  logic [WordLen-1:0]    rfWdata_q;
  logic [WordLen-1:0]    rfWdata_d;

  // Grant logic. Ready is purely combinational from the valids and the
  // last-grant pointer; a lone requester always wins, and under contention
  // the requester that did not win last time goes first. Nothing is granted
  // while reset is held.
  always_comb begin
    grantWb  = 1'b0;
    grantMem = 1'b0;
    if (rst) begin
      if (wb_valid && mem_valid) begin
        if (lastGrant_q == REQ_MEM) begin
          grantWb = 1'b1;
        end else begin
          grantMem = 1'b1;
        end
      end else begin
        grantWb  = wb_valid;
        grantMem = mem_valid;
      end
    end
  end

  assign wb_ready  = grantWb;
  assign mem_ready = grantMem;
  assign transfer  = grantWb || grantMem;

  // Next-state for the pointer and the output register. A transfer to the
  // PC slot is accepted and loads addr/data, but never raises the enable.
  always_comb begin
    wbReq.addr  = wb_addr;
    wbReq.data  = wb_data;
    memReq.addr = mem_addr;
    memReq.data = mem_data;
    winReq      = grantMem ? memReq : wbReq;

    lastGrant_d = lastGrant_q;
    rfWe_d      = 1'b0;
    rfWaddr_d   = rfWaddr_q;
    rfWdata_d   = rfWdata_q;
    if (transfer) begin
      lastGrant_d = grantMem ? REQ_MEM : REQ_WB;
      rfWe_d      = is_writable(winReq.addr);
      rfWaddr_d   = winReq.addr;
      rfWdata_d   = winReq.data;
    end
  end

  // Reset leaves the pointer on MEM so WB wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGrant_q <= REQ_MEM;
      rfWe_q      <= 1'b0;
      rfWaddr_q   <= '0;
      rfWdata_q   <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      rfWe_q      <= rfWe_d;
      rfWaddr_q   <= rfWaddr_d;
      rfWdata_q   <= rfWdata_d;
    end
  end

  assign rf_we    = rfWe_q;
  assign rf_waddr = rfWaddr_q;
  assign rf_wdata = rfWdata_q;

`ifdef REGWR_SCOREBOARD_EN
  // Only a memory-return transfer retires an outstanding load.
  regwr_scoreboard u_scoreboard (
    .clk_i       (clk),
    .rst_ni      (rst),
    .rsv_valid_i (rsv_valid),
    .rsv_addr_i  (rsv_addr),
    .rsv_ready_o (rsv_ready),
    .clr_valid_i (grantMem),
    .clr_addr_i  (mem_addr),
    .busy_o      (busy)
  );
`else
  // Without the scoreboard reservations are always accepted and forgotten.
  logic unusedRsv;

  assign unusedRsv = rsv_valid ^ (^rsv_addr);
  assign rsv_ready = rst;
  assign busy      = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Self-checking bench for regfile_write_arbiter. Builds with or without
// REGWR_SCOREBOARD_EN; expectations follow the same macro.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int G_NONE = 0;
  localparam int G_WB   = 1;
  localparam int G_MEM  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbValid = 1'b0;
  logic        wbReady;
  logic [3:0]  wbAddr = '0;
  logic [31:0] wbData = '0;
  logic        memValid = 1'b0;
  logic        memReady;
  logic [3:0]  memAddr = '0;
  logic [31:0] memData = '0;
  logic        rsvValid = 1'b0;
  logic        rsvReady;
  logic [3:0]  rsvAddr = '0;
  logic        rfWe;
  logic [3:0]  rfWaddr;
  logic [31:0] rfWdata;
  logic [14:0] busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state: who won last, what the write port should show,
  // and which registers have an outstanding load.
  int          mLast;
  bit          mWe;
  bit   [3:0]  mWaddr;
  bit   [31:0] mWdata;
  bit          mBusy [15];
  int          lastGrant;
  bit          lastRsvFire;

  // Behavioural register file committing on the negative edge.
  logic [31:0] rfMem [15];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rfWe && rfWaddr < 4'd15) rfMem[rfWaddr] <= rfWdata;
  end

  regfile_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wbValid),
    .wb_ready  (wbReady),
    .wb_addr   (wbAddr),
    .wb_data   (wbData),
    .mem_valid (memValid),
    .mem_ready (memReady),
    .mem_addr  (memAddr),
    .mem_data  (memData),
    .rsv_valid (rsvValid),
    .rsv_ready (rsvReady),
    .rsv_addr  (rsvAddr),
    .rf_we     (rfWe),
    .rf_waddr  (rfWaddr),
    .rf_wdata  (rfWdata),
    .busy      (busy)
  );

  function automatic int expGrant();
    if (!rst) return G_NONE;
    if (wbValid && memValid) return (mLast == G_MEM) ? G_WB : G_MEM;
    if (wbValid) return G_WB;
    if (memValid) return G_MEM;
    return G_NONE;
  endfunction

  function automatic bit expRsvReady();
    if (!rst) return 1'b0;
`ifdef REGWR_SCOREBOARD_EN
    if (rsvAddr == 4'd15) return 1'b0;
    return !mBusy[rsvAddr];
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [14:0] busyVec();
    logic [14:0] v;
    for (int i = 0; i < 15; i++) v[i] = mBusy[i];
    return v;
  endfunction

  task automatic modelReset();
    mLast       = G_MEM;
    mWe         = 1'b0;
    mWaddr      = '0;
    mWdata      = '0;
    lastGrant   = G_NONE;
    lastRsvFire = 1'b0;
    for (int i = 0; i < 15; i++) mBusy[i] = 1'b0;
  endtask

  // Advance one clock with the current inputs and update the model from the
  // handshakes that happen at that edge.
  task automatic tick();
    int g;
    bit rf;
    g  = expGrant();
    rf = rsvValid && expRsvReady();
    @(posedge clk);
    lastGrant   = g;
    lastRsvFire = rf;
    if (g == G_WB) begin
      mWe = (wbAddr != 4'd15); mWaddr = wbAddr; mWdata = wbData; mLast = G_WB;
    end else if (g == G_MEM) begin
      mWe = (memAddr != 4'd15); mWaddr = memAddr; mWdata = memData; mLast = G_MEM;
    end else begin
      mWe = 1'b0;
    end
`ifdef REGWR_SCOREBOARD_EN
    if (rf) mBusy[rsvAddr] = 1'b1;
    if (g == G_MEM && memAddr != 4'd15) mBusy[memAddr] = 1'b0;
`endif
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b0;
    wbValid = 1'b0; memValid = 1'b0; rsvValid = 1'b0;
    #1;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    wbValid = 1'b1; wbAddr = 4'd1; wbData = 32'h1111_1111;
    memValid = 1'b1; memAddr = 4'd2; memData = 32'h2222_2222;
    rsvValid = 1'b1; rsvAddr = 4'd4;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({wbReady, memReady, rsvReady} !== 3'b000)
        $display("[TB] FAIL reset_ready: got wb=%b mem=%b rsv=%b expected 000", wbReady, memReady, rsvReady);
      checks++;
      if (rfWe !== 1'b0 || busy !== 15'h0 || rfWaddr !== 4'h0 || rfWdata !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_outputs: got we=%b busy=%h addr=%h data=%h expected all zero", rfWe, busy, rfWaddr, rfWdata);
      end
      if ({wbReady, memReady, rsvReady} !== 3'b000) failures++;
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    rsvValid = 1'b0;
    #1;
    checks++;
    if (wbReady !== 1'b1 || memReady !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_first_grant: got wb=%b mem=%b expected wb=1 mem=0", wbReady, memReady);
    end
    tick();
    wbValid = 1'b0;
    checks++;
    if (rfWe !== 1'b1 || rfWaddr !== 4'd1 || rfWdata !== 32'h1111_1111) begin
      failures++;
      $display("[TB] FAIL reset_first_write: got we=%b addr=%h data=%h expected 1 1 11111111", rfWe, rfWaddr, rfWdata);
    end
    #1;
    checks++;
    if (memReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mem_follow: got mem_ready=%b expected 1", memReady);
    end
    tick();
    memValid = 1'b0;
    checks++;
    if (rfWe !== 1'b1 || rfWaddr !== 4'd2 || rfWdata !== 32'h2222_2222) begin
      failures++;
      $display("[TB] FAIL reset_mem_write: got we=%b addr=%h data=%h expected 1 2 22222222", rfWe, rfWaddr, rfWdata);
    end
  endtask

  task automatic test_single();
    resetDut();
    wbValid = 1'b1; wbAddr = 4'd3; wbData = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (wbReady !== 1'b1 || memReady !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_ready: got wb=%b mem=%b expected 1 0", wbReady, memReady);
    end
    tick();
    wbValid = 1'b0;
    checks++;
    if (rfWe !== 1'b1 || rfWaddr !== 4'd3 || rfWdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL single_write: got we=%b addr=%h data=%h expected 1 3 deadbeef", rfWe, rfWaddr, rfWdata);
    end
    tick();
    checks++;
    if (rfWe !== 1'b0 || rfWaddr !== 4'd3 || rfWdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL single_idle_hold: got we=%b addr=%h data=%h expected 0 3 deadbeef", rfWe, rfWaddr, rfWdata);
    end
    checks++;
    if (rfMem[3] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL single_commit: got reg3=%h expected deadbeef", rfMem[3]);
    end
  endtask

  task automatic test_contention();
    bit expWb;
    resetDut();
    wbValid = 1'b1;  wbAddr = 4'd1;  wbData = 32'hA5A5_0001;
    memValid = 1'b1; memAddr = 4'd2; memData = 32'h5A5A_0002;
    for (int i = 0; i < 6; i++) begin
      expWb = (i % 2 == 0);
      #1;
      checks++;
      if (wbReady !== expWb || memReady !== !expWb) begin
        failures++;
        $display("[TB] FAIL contention_grant[%0d]: got wb=%b mem=%b expected wb=%b mem=%b", i, wbReady, memReady, expWb, !expWb);
      end
      tick();
      checks++;
      if (rfWe !== 1'b1 || rfWaddr !== (expWb ? 4'd1 : 4'd2)) begin
        failures++;
        $display("[TB] FAIL contention_write[%0d]: got we=%b addr=%h expected 1 %0d", i, rfWe, rfWaddr, expWb ? 1 : 2);
      end
    end
    wbValid = 1'b0; memValid = 1'b0;
    tick();
  endtask

  task automatic test_scoreboard();
    resetDut();
    rsvValid = 1'b1; rsvAddr = 4'd5;
    #1;
    checks++;
    if (rsvReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sb_first_rsv: got rsv_ready=%b expected 1", rsvReady);
    end
    tick();
    checks++;
`ifdef REGWR_SCOREBOARD_EN
    if (busy !== 15'h0020) begin
`else
    if (busy !== 15'h0000) begin
`endif
      failures++;
      $display("[TB] FAIL sb_busy_set: got busy=%h", busy);
    end
    #1;
    checks++;
`ifdef REGWR_SCOREBOARD_EN
    if (rsvReady !== 1'b0) begin
`else
    if (rsvReady !== 1'b1) begin
`endif
      failures++;
      $display("[TB] FAIL sb_second_rsv: got rsv_ready=%b", rsvReady);
    end
    tick();
    memValid = 1'b1; memAddr = 4'd5; memData = 32'hCAFE_0005;
    #1;
    checks++;
`ifdef REGWR_SCOREBOARD_EN
    if (memReady !== 1'b1 || rsvReady !== 1'b0) begin
`else
    if (memReady !== 1'b1 || rsvReady !== 1'b1) begin
`endif
      failures++;
      $display("[TB] FAIL sb_same_cycle_ready: got mem_ready=%b rsv_ready=%b", memReady, rsvReady);
    end
    tick();
    memValid = 1'b0;
    checks++;
    if (busy !== 15'h0000) begin
      failures++;
      $display("[TB] FAIL sb_clear: got busy=%h expected 0000", busy);
    end
    #1;
    checks++;
    if (rsvReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sb_retry_ready: got rsv_ready=%b expected 1", rsvReady);
    end
    tick();
    rsvValid = 1'b0;
    checks++;
`ifdef REGWR_SCOREBOARD_EN
    if (busy !== 15'h0020) begin
`else
    if (busy !== 15'h0000) begin
`endif
      failures++;
      $display("[TB] FAIL sb_retry_set: got busy=%h", busy);
    end
  endtask

  task automatic test_pc_guard();
    memValid = 1'b1; memAddr = 4'd15; memData = 32'h0BAD_F00D;
    rsvValid = 1'b1; rsvAddr = 4'd15;
    #1;
    checks++;
    if (memReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pc_mem_ready: got mem_ready=%b expected 1", memReady);
    end
    checks++;
`ifdef REGWR_SCOREBOARD_EN
    if (rsvReady !== 1'b0) begin
`else
    if (rsvReady !== 1'b1) begin
`endif
      failures++;
      $display("[TB] FAIL pc_rsv_ready: got rsv_ready=%b", rsvReady);
    end
    tick();
    memValid = 1'b0; rsvValid = 1'b0;
    checks++;
    if (rfWe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pc_no_write: got we=%b expected 0", rfWe);
    end
    checks++;
    if (busy !== busyVec()) begin
      failures++;
      $display("[TB] FAIL pc_busy_unchanged: got busy=%h expected %h", busy, busyVec());
    end
  endtask

  task automatic test_random();
    int g;
    bit rr;
    resetDut();
    for (int i = 0; i < 400; i++) begin
      if (!wbValid || lastGrant == G_WB) begin
        wbValid = ($urandom_range(0, 3) != 0);
        wbAddr  = 4'($urandom_range(0, 15));
        wbData  = $urandom();
      end
      if (!memValid || lastGrant == G_MEM) begin
        memValid = ($urandom_range(0, 2) != 0);
        memAddr  = 4'($urandom_range(0, 15));
        memData  = $urandom();
      end
      if (!rsvValid || lastRsvFire) begin
        rsvValid = ($urandom_range(0, 2) == 0);
        rsvAddr  = 4'($urandom_range(0, 14));
      end
      #1;
      g  = expGrant();
      rr = expRsvReady();
      checks++;
      if (wbReady !== (g == G_WB) || memReady !== (g == G_MEM) || rsvReady !== rr) begin
        failures++;
        $display("[TB] FAIL random_ready[%0d]: got wb=%b mem=%b rsv=%b expected %b %b %b", i, wbReady, memReady, rsvReady, g == G_WB, g == G_MEM, rr);
      end
      tick();
      checks++;
      if (rfWe !== mWe || rfWaddr !== mWaddr || rfWdata !== mWdata || busy !== busyVec()) begin
        failures++;
        $display("[TB] FAIL random_out[%0d]: got we=%b addr=%h data=%h busy=%h expected %b %h %h %h", i, rfWe, rfWaddr, rfWdata, busy, mWe, mWaddr, mWdata, busyVec());
      end
    end
  endtask

  task automatic test_midreset();
    wbValid = 1'b1; wbAddr = 4'd7; wbData = 32'h7777_7777;
    memValid = 1'b1; memAddr = 4'd8; memData = 32'h8888_8888;
    rsvValid = 1'b1; rsvAddr = 4'd9;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checks++;
    if ({wbReady, memReady, rsvReady} !== 3'b000 || rfWe !== 1'b0 || rfWaddr !== 4'h0 ||
        rfWdata !== 32'h0 || busy !== 15'h0) begin
      failures++;
      $display("[TB] FAIL midreset: got rdy=%b%b%b we=%b addr=%h data=%h busy=%h expected all zero",
               wbReady, memReady, rsvReady, rfWe, rfWaddr, rfWdata, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (wbReady !== 1'b1 || memReady !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_regrant: got wb=%b mem=%b expected 1 0", wbReady, memReady);
    end
    wbValid = 1'b0; memValid = 1'b0; rsvValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_scoreboard();
    test_pc_guard();
    test_random();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
